// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, in-order instruction memory requests and prefetch FIFO
// Redirects flush the FIFO and drop responses that were already in flight.
module instruction_fetch_unit #(
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter int                    DATA_WIDTH        = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR      = 32'h0000_0000,
  parameter int                    BUFFER_DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         memReqValid,
  input  logic                         memReqReady,
  output logic [DATA_WIDTH-1:0]        memReqAddr,
  input  logic                         memRespValid,
  input  logic [INSTRUCTION_WIDTH-1:0] memRespData,
  output logic                         instrValid,
  input  logic                         decodeReady,
  output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
  output logic [DATA_WIDTH-1:0]        instrPc,
  input  logic                         redirectValid,
  input  logic [DATA_WIDTH-1:0]        redirectTarget,
  output logic                         fetchError
);
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(BUFFER_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                       state;
  state_t                       state_next;
  logic [DATA_WIDTH-1:0]        fetch_pc;
  logic [DATA_WIDTH-1:0]        resp_pc;
  logic [CW-1:0]                outstanding;
  logic [CW-1:0]                drop_count;
  logic [CW-1:0]                fifo_count;
  logic [PW-1:0]                rd_ptr;
  logic [PW-1:0]                wr_ptr;
  logic [INSTRUCTION_WIDTH-1:0] fifo_instr [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0]        fifo_pc    [BUFFER_DEPTH];
  logic                         fetch_error;
  logic                         redirect;
  logic                         misaligned;
  logic                         req_fire;
  logic                         resp_fire;
  logic                         push;
  logic                         pop;
  logic [CW:0]                  in_use;

  assign redirect   = (state == RUN) && redirectValid;
  assign misaligned = (redirectTarget[1:0] != 2'b00);
  assign in_use     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req_fire   = memReqValid && memReqReady;
  // A response with nothing outstanding is stale (e.g. issued before reset).
  assign resp_fire  = memRespValid && (outstanding != '0);
  assign push       = resp_fire && (drop_count == '0) && !redirect && (state == RUN);
  assign pop        = instrValid && decodeReady && !redirect;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect && misaligned) begin
      state_next = HALT;
    end
  end

  always_comb begin
    memReqValid    = 1'b0;
    memReqAddr     = RESET_VECTOR;
    instrValid     = 1'b0;
    instructionOut = '0;
    instrPc        = '0;
    fetchError     = 1'b0;
    if (reset) begin
      // Outstanding plus buffered never exceeds the FIFO, so responses always fit.
      memReqValid    = (state == RUN) && !redirectValid && (in_use < DEPTH_LIMIT);
      memReqAddr     = fetch_pc;
      instrValid     = (state == RUN) && (fifo_count != '0);
      instructionOut = fifo_instr[rd_ptr];
      instrPc        = fifo_pc[rd_ptr];
      fetchError     = fetch_error;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= '0;
      drop_count  <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fetch_error <= 1'b0;
    end else if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc    <= redirectTarget;
      resp_pc     <= redirectTarget;
      outstanding <= outstanding - CW'(resp_fire);
      drop_count  <= outstanding - CW'(resp_fire);
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      if (misaligned) begin
        fetch_error <= 1'b1;
      end
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + DATA_WIDTH'(4);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
      if (resp_fire && (drop_count != '0)) begin
        drop_count <= drop_count - CW'(1);
      end
      if (push) begin
        resp_pc <= resp_pc + DATA_WIDTH'(4);
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= memRespData;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        memReqValid, memReqReady, memRespValid, instrValid, decodeReady;
  logic        redirectValid, fetchError;
  logic [31:0] memReqAddr, memRespData, instructionOut, instrPc, redirectTarget;
  logic        memReqValid_w, memRespValid_w, instrValid_w, fetchError_w;
  logic [31:0] memReqAddr_w, memRespData_w, instructionOut_w, instrPc_w;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mem_lat = 1;
  logic [31:0] pq_addr[$];
  int          pq_due[$];
  logic [31:0] req_log[$], del_pc[$], del_ins[$];
  logic [31:0] req_log_w[$], del_pc_w[$], del_ins_w[$];
  logic        p_v;
  logic [31:0] p_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_fetch_unit #(
    .INSTRUCTION_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0000_0000), .BUFFER_DEPTH(2)
  ) u_dut (
    .clk(clk), .reset(reset),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .instrValid(instrValid), .decodeReady(decodeReady),
    .instructionOut(instructionOut), .instrPc(instrPc),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget), .fetchError(fetchError)
  );

  instruction_fetch_unit #(
    .INSTRUCTION_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFF8), .BUFFER_DEPTH(2)
  ) u_dut_wrap (
    .clk(clk), .reset(reset),
    .memReqValid(memReqValid_w), .memReqReady(1'b1), .memReqAddr(memReqAddr_w),
    .memRespValid(memRespValid_w), .memRespData(memRespData_w),
    .instrValid(instrValid_w), .decodeReady(1'b1),
    .instructionOut(instructionOut_w), .instrPc(instrPc_w),
    .redirectValid(1'b0), .redirectTarget(32'h0), .fetchError(fetchError_w)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] q[$], input int i,
                         input logic [31:0] exp);
    check(tag, (i < q.size()) ? q[i] : 32'hBAD0_BAD0, exp);
  endtask

  task automatic clear_logs();
    req_log.delete(); del_pc.delete(); del_ins.delete();
    req_log_w.delete(); del_pc_w.delete(); del_ins_w.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    redirectValid = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    reset = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirectValid  = 1'b1;
    redirectTarget = target;
    #1 check("redirect_gates_req", {31'b0, memReqValid}, 32'd0);
    @(negedge clk);
    redirectValid = 1'b0;
    clear_logs();
  endtask

  // Main-DUT memory: in-order, mem_lat edges from accept to response; also logs traffic.
  initial begin
    memRespValid = 1'b0;
    memRespData  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        pq_addr.delete();
        pq_due.delete();
        memRespValid = 1'b0;
      end else begin
        if (pq_due.size() > 0 && pq_due[0] == cyc + 1) begin
          memRespValid = 1'b1;
          memRespData  = instr_of(pq_addr[0]);
          void'(pq_addr.pop_front());
          void'(pq_due.pop_front());
        end else begin
          memRespValid = 1'b0;
        end
        if (memReqValid && memReqReady) begin
          pq_addr.push_back(memReqAddr);
          pq_due.push_back(cyc + 1 + mem_lat);
          req_log.push_back(memReqAddr);
        end
        if (instrValid && decodeReady) begin
          del_pc.push_back(instrPc);
          del_ins.push_back(instructionOut);
        end
      end
    end
  end

  // Wrap-DUT memory: fixed 1-cycle latency, always ready.
  initial begin
    p_v = 1'b0;
    p_a = '0;
    memRespValid_w = 1'b0;
    memRespData_w  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        p_v = 1'b0;
        memRespValid_w = 1'b0;
      end else begin
        memRespValid_w = p_v;
        memRespData_w  = instr_of(p_a);
        p_v = memReqValid_w;
        p_a = memReqAddr_w;
        if (memReqValid_w && req_log_w.size() < 8) req_log_w.push_back(memReqAddr_w);
        if (instrValid_w && del_pc_w.size() < 8) begin
          del_pc_w.push_back(instrPc_w);
          del_ins_w.push_back(instructionOut_w);
        end
      end
    end
  end

  initial begin
    reset          = 1'b0;
    memReqReady    = 1'b1;
    decodeReady    = 1'b1;
    redirectValid  = 1'b0;
    redirectTarget = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_memReqValid", {31'b0, memReqValid}, 32'd0);
    check("rst_memReqAddr", memReqAddr, 32'h0000_0000);
    check("rst_memReqAddr_wrap", memReqAddr_w, 32'hFFFF_FFF8);
    check("rst_instrValid", {31'b0, instrValid}, 32'd0);
    check("rst_instructionOut", instructionOut, 32'd0);
    check("rst_instrPc", instrPc, 32'd0);
    check("rst_fetchError", {31'b0, fetchError}, 32'd0);

    // Streaming with 1-cycle memory
    mem_lat = 1;
    do_reset();
    repeat (12) @(negedge clk);
    check_q("t1_req0", req_log, 0, 32'h0);
    check_q("t1_req1", req_log, 1, 32'h4);
    check_q("t1_req2", req_log, 2, 32'h8);
    check_q("t1_pc0", del_pc, 0, 32'h0);
    check_q("t1_pc1", del_pc, 1, 32'h4);
    check_q("t1_pc2", del_pc, 2, 32'h8);
    check_q("t1_pc3", del_pc, 3, 32'hC);
    check_q("t1_ins1", del_ins, 1, 32'h5A5A_A5A1);
    check_q("t1_ins3", del_ins, 3, 32'h5A5A_A5A9);
    check_q("wrap_req0", req_log_w, 0, 32'hFFFF_FFF8);
    check_q("wrap_req1", req_log_w, 1, 32'hFFFF_FFFC);
    check_q("wrap_req2", req_log_w, 2, 32'h0000_0000);
    check_q("wrap_pc0", del_pc_w, 0, 32'hFFFF_FFF8);
    check_q("wrap_pc1", del_pc_w, 1, 32'hFFFF_FFFC);
    check_q("wrap_pc2", del_pc_w, 2, 32'h0000_0000);
    check_q("wrap_ins2", del_ins_w, 2, 32'h5A5A_A5A5);

    // Decode stalled: buffer fills, requests stop
    decodeReady = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    check("t2_req_count", req_log.size(), 32'd2);
    check_q("t2_req1", req_log, 1, 32'h4);
    check("t2_memReqValid", {31'b0, memReqValid}, 32'd0);
    check("t2_instrValid", {31'b0, instrValid}, 32'd1);
    check("t2_head_pc", instrPc, 32'h0);
    check("t2_head_ins", instructionOut, 32'h5A5A_A5A5);
    decodeReady = 1'b1;
    repeat (10) @(negedge clk);
    check_q("t2_pc0", del_pc, 0, 32'h0);
    check_q("t2_pc1", del_pc, 1, 32'h4);
    check_q("t2_pc2", del_pc, 2, 32'h8);
    check_q("t2_ins2", del_ins, 2, 32'h5A5A_A5AD);

    // 3-cycle memory, two in flight, redirect to 0x100
    mem_lat = 3;
    do_reset();
    repeat (2) @(negedge clk);
    #1 check("t3_two_in_flight", {31'b0, memReqValid}, 32'd0);
    pulse_redirect(32'h0000_0100);
    repeat (20) @(negedge clk);
    check_q("t3_req0", req_log, 0, 32'h100);
    check_q("t3_pc0", del_pc, 0, 32'h100);
    check_q("t3_ins0", del_ins, 0, 32'h5A5A_A4A5);
    check_q("t3_pc1", del_pc, 1, 32'h104);

    // Redirect coinciding with a response and a decode pop
    mem_lat = 1;
    do_reset();
    repeat (2) @(negedge clk);
    pulse_redirect(32'h0000_0040);
    #1;
    check("t4_flushed", {31'b0, instrValid}, 32'd0);
    check("t4_req_valid", {31'b0, memReqValid}, 32'd1);
    check("t4_req_addr", memReqAddr, 32'h40);
    repeat (8) @(negedge clk);
    check_q("t4_pc0", del_pc, 0, 32'h40);
    check_q("t4_ins0", del_ins, 0, 32'h5A5A_A5E5);
    check_q("t4_pc1", del_pc, 1, 32'h44);

    // Misaligned target halts until reset
    do_reset();
    repeat (4) @(negedge clk);
    pulse_redirect(32'h0000_0102);
    #1;
    check("t5_err_set", {31'b0, fetchError}, 32'd1);
    check("t5_req_off", {31'b0, memReqValid}, 32'd0);
    check("t5_valid_off", {31'b0, instrValid}, 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("t5_err_sticky", {31'b0, fetchError}, 32'd1);
    check("t5_req_still_off", {31'b0, memReqValid}, 32'd0);
    check("t5_no_delivery", del_pc.size(), 32'd0);
    do_reset();
    #1 check("t5_err_cleared", {31'b0, fetchError}, 32'd0);
    repeat (8) @(negedge clk);
    check_q("t5_restart_pc0", del_pc, 0, 32'h0);
    check_q("t5_restart_pc1", del_pc, 1, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
